tlk2711_rx_checker: RTL and testbench
=====================================

TLK2711_RX_CHECKER -- requirements
Module: tlk2711_rx_checker

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 4, meaning consecutive good frames required to assert o_sync (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, recovered receive clock; all logic in this domain.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port i_enable, input, 1, checker enable; low forces HUNT and blocks all counting.
REQ-005 SHALL have port i_clr, input, 1, synchronous clear of all counters and error capture.
REQ-006 SHALL have port i_rkmsb, input, 1, K-flag for i_rxd[15:8].
REQ-007 SHALL have port i_rklsb, input, 1, K-flag for i_rxd[7:0].
REQ-008 SHALL have port i_rxd, input, 16, received word.
REQ-009 SHALL have port o_sync, output, 1, frame lock indicator.
REQ-010 SHALL have port o_frame_ok, output, 1, one-cycle pulse per good frame.
REQ-011 SHALL have port o_frame_err, output, 1, one-cycle pulse per bad or truncated frame.
REQ-012 SHALL have port o_frame_cnt, output, 32, good-frame count.
REQ-013 SHALL have port o_ferr_cnt, output, 16, bad-frame count.
REQ-014 SHALL have port o_werr_cnt, output, 32, bad-payload-word count.
REQ-015 SHALL have port o_err_idx, output, 5, payload index of first bad word since clear.
REQ-016 SHALL have port o_err_word, output, 16, received value of first bad word since clear.

Function
REQ-017 SHALL classify words as follows: COMMA = rkmsb=0, rklsb=1, rxd=16'hC5BC; SOF = rkmsb=0, rklsb=1, rxd=16'hABBC; DATA(n) = rkmsb=0, rklsb=0, rxd={3'b0,n,3'b0,n}.
REQ-018 SHALL implement states HUNT, COMMA, DATA; the payload index is a 5-bit counter starting at 0 in DATA.
REQ-019 SHALL, in HUNT: COMMA -> COMMA; any other word -> stay in HUNT, with no error counted.
REQ-020 SHALL, in COMMA: COMMA -> stay; SOF -> DATA with index 0; any other word -> HUNT and, if o_sync=1, count a frame error.
REQ-021 SHALL, in DATA, compare each word against DATA(index) and increment o_werr_cnt on mismatch, including any K-flag set.
REQ-022 SHALL, in DATA, treat a word with index 31 as end of frame: next state HUNT; o_frame_ok if all 32 words matched, else o_frame_err.
REQ-023 SHALL, in DATA, treat a COMMA before index 31 as a truncated frame: pulse o_frame_err, increment o_ferr_cnt, go to COMMA, and not count it as a word error.
REQ-024 SHALL assert o_frame_ok/o_frame_err in the cycle after the clock edge that samples the terminating word, for exactly one cycle, never both.
REQ-025 SHALL keep a consecutive-good counter: +1 on each good frame, saturating at LOCK_FRAMES; cleared on any frame error.
REQ-026 SHALL set o_sync when the consecutive-good counter reaches LOCK_FRAMES, and clear it on the same edge as any frame error.
REQ-027 SHALL saturate every counter at all-ones with no wrap.
REQ-028 SHALL give i_clr priority over a same-cycle increment: counters read 0 on the next cycle; FSM and o_sync are unaffected.
REQ-029 SHALL, when i_enable=0, force state to HUNT, clear o_sync and the consecutive-good counter, hold counters, and suppress pulses; a frame in progress is discarded without error.
REQ-030 SHALL produce all outputs directly from registers, with no combinational path from inputs.

Reset
REQ-031 SHALL, on rst, set state=HUNT, index=0, o_sync=0, both pulses=0, all counters=0, o_err_idx=0, o_err_word=0.
REQ-032 SHALL, on rst asserted mid-frame, abandon the frame with no pulse and no count; after release, a complete comma/SOF sequence is required before checking resumes.

Configuration
REQ-033 SHALL use macro TLK2711_RX_ERRCAP_EN: when defined, the first bad payload word after reset or i_clr latches its index into o_err_idx and its i_rxd into o_err_word, held until the next clear.
REQ-034 SHALL, when TLK2711_RX_ERRCAP_EN is undefined, keep the o_err_idx and o_err_word ports present and tied to 0, with no capture registers.

Verification
REQ-035 SHALL cover: 4x (COMMA,COMMA,SOF,DATA 0..31) -> 4 o_frame_ok pulses, o_frame_cnt=4, o_sync=1 in the cycle after the 4th pulse, o_werr_cnt=0.
REQ-036 SHALL cover: locked, then frame with word 7 = 16'h0807 -> o_frame_err, o_werr_cnt=1, o_ferr_cnt=1, o_sync=0; with macro, o_err_idx=7 and o_err_word=16'h0807.
REQ-037 SHALL cover: COMMA after DATA index 10 -> o_frame_err, o_ferr_cnt+1, o_werr_cnt unchanged, state COMMA, and the next SOF frame is checked normally.
REQ-038 SHALL cover: continuous COMMA stream for 1000 cycles (loopback/K-code traffic) -> no pulses, all counters 0.
REQ-039 SHALL cover: i_clr asserted on the same edge that ends a good frame -> o_frame_cnt=0 next cycle; o_frame_ok still pulses.
REQ-040 SHALL cover: rst asserted at DATA index 15 -> all outputs 0; after release, DATA words alone produce no count until COMMA and SOF are seen.

Source files
------------

// File: rtl/tlk2711_rx_checker.sv
// rtl/tlk2711_rx_checker.sv - TLK2711 receive frame checker (optional error capture: TLK2711_RX_ERRCAP_EN)
module tlk2711_rx_checker #(
  parameter int LOCK_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_clr,
  input  logic        i_rkmsb,
  input  logic        i_rklsb,
  input  logic [15:0] i_rxd,
  output logic        o_sync,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_ferr_cnt,
  output logic [31:0] o_werr_cnt,
  output logic [4:0]  o_err_idx,
  output logic [15:0] o_err_word
);

  localparam logic [1:0] S_HUNT  = 2'd0;
  localparam logic [1:0] S_COMMA = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [3:0] LOCK    = 4'(LOCK_FRAMES);

  logic [1:0] state, next_state;
  logic [4:0] idx, next_idx;
  logic       frame_bad, next_bad;
  logic [3:0] good_cnt;
  logic       is_comma, is_sof, word_ok;
  logic       ev_ok, ev_err, ev_werr;

  assign is_comma = !i_rkmsb && i_rklsb && (i_rxd == 16'hC5BC);
  assign is_sof   = !i_rkmsb && i_rklsb && (i_rxd == 16'hABBC);
  assign word_ok  = !i_rkmsb && !i_rklsb && (i_rxd == {3'b000, idx, 3'b000, idx});

  // Next-state decode and per-word frame events
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_bad   = frame_bad;
    ev_ok      = 1'b0;
    ev_err     = 1'b0;
    ev_werr    = 1'b0;
    case (state)
      S_HUNT: begin
        if (is_comma) next_state = S_COMMA;
      end
      S_COMMA: begin
        if (is_sof) begin
          next_state = S_DATA;
          next_idx   = 5'd0;
          next_bad   = 1'b0;
        end else if (!is_comma) begin
          next_state = S_HUNT;
          ev_err     = o_sync;
        end
      end
      S_DATA: begin
        if (is_comma && idx != 5'd31) begin
          // Truncated frame: re-align on the comma, not a payload error
          next_state = S_COMMA;
          ev_err     = 1'b1;
        end else begin
          ev_werr = !word_ok;
          if (idx == 5'd31) begin
            next_state = S_HUNT;
            ev_ok      = !frame_bad && word_ok;
            ev_err     = frame_bad || !word_ok;
          end else begin
            next_idx = idx + 5'd1;
            next_bad = frame_bad || !word_ok;
          end
        end
      end
      default: next_state = S_HUNT;
    endcase
  end

  // FSM, frame pulses and lock tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HUNT;
      idx         <= 5'd0;
      frame_bad   <= 1'b0;
      good_cnt    <= 4'd0;
      o_sync      <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
    end else if (!i_enable) begin
      state       <= S_HUNT;
      idx         <= 5'd0;
      frame_bad   <= 1'b0;
      good_cnt    <= 4'd0;
      o_sync      <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= next_state;
      idx         <= next_idx;
      frame_bad   <= next_bad;
      o_frame_ok  <= ev_ok;
      o_frame_err <= ev_err;
      if (ev_err) begin
        good_cnt <= 4'd0;
        o_sync   <= 1'b0;
      end else if (ev_ok) begin
        if (good_cnt < LOCK) good_cnt <= good_cnt + 4'd1;
        if (good_cnt >= LOCK - 4'd1) o_sync <= 1'b1;
      end
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      o_frame_cnt <= 32'd0;
      o_ferr_cnt  <= 16'd0;
      o_werr_cnt  <= 32'd0;
    end else if (i_enable) begin
      if (ev_ok && o_frame_cnt != '1) o_frame_cnt <= o_frame_cnt + 32'd1;
      if (ev_err && o_ferr_cnt != '1) o_ferr_cnt <= o_ferr_cnt + 16'd1;
      if (ev_werr && o_werr_cnt != '1) o_werr_cnt <= o_werr_cnt + 32'd1;
    end
  end

`ifdef TLK2711_RX_ERRCAP_EN
  logic err_held;

  // Latch the first bad payload word since reset or clear
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      err_held   <= 1'b0;
      o_err_idx  <= 5'd0;
      o_err_word <= 16'd0;
    end else if (i_enable && ev_werr && !err_held) begin
      err_held   <= 1'b1;
      o_err_idx  <= idx;
      o_err_word <= i_rxd;
    end
  end
`else
  assign o_err_idx  = 5'd0;
  assign o_err_word = 16'd0;
`endif

endmodule

// File: tb/tb_tlk2711_rx_checker.sv
// tb/tb_tlk2711_rx_checker.sv - scoreboard bench for tlk2711_rx_checker
module tb_tlk2711_rx_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic        i_clr;
  logic        i_rkmsb;
  logic        i_rklsb;
  logic [15:0] i_rxd;
  logic        o_sync;
  logic        o_frame_ok;
  logic        o_frame_err;
  logic [31:0] o_frame_cnt;
  logic [15:0] o_ferr_cnt;
  logic [31:0] o_werr_cnt;
  logic [4:0]  o_err_idx;
  logic [15:0] o_err_word;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];  // 1 = expect o_frame_ok, 0 = expect o_frame_err

  tlk2711_rx_checker #(.LOCK_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_clr(i_clr),
    .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb), .i_rxd(i_rxd),
    .o_sync(o_sync), .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err),
    .o_frame_cnt(o_frame_cnt), .o_ferr_cnt(o_ferr_cnt), .o_werr_cnt(o_werr_cnt),
    .o_err_idx(o_err_idx), .o_err_word(o_err_word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dword(input int n);
    logic [4:0] v;
    v = n[4:0];
    return {3'b000, v, 3'b000, v};
  endfunction

  // Apply a word for exactly one rising edge; returns #1 after that edge
  task automatic send(input logic mk, input logic lk, input logic [15:0] d);
    i_rkmsb = mk;
    i_rklsb = lk;
    i_rxd   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic comma();
    send(1'b0, 1'b1, 16'hC5BC);
  endtask

  task automatic sof();
    send(1'b0, 1'b1, 16'hABBC);
  endtask

  task automatic data_run(input int from, input int to);
    for (int n = from; n <= to; n++) send(1'b0, 1'b0, dword(n));
  endtask

  // Full frame; bad_at < 0 means all payload words correct
  task automatic send_frame(input int bad_at, input logic [15:0] bad_val, input bit clr_last);
    comma();
    comma();
    sof();
    for (int n = 0; n < 32; n++) begin
      if (n == 31) begin
        exp_q.push_back(bad_at < 0);
        i_clr = clr_last;
      end
      if (n == bad_at) send(1'b0, 1'b0, bad_val);
      else send(1'b0, 1'b0, dword(n));
      i_clr = 1'b0;
    end
  endtask

  // Monitor: every pulse must match the next expected frame result
  always @(negedge clk) begin
    if (o_frame_ok || o_frame_err) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pulse_unexpected: ok=%0b err=%0b expected none", o_frame_ok, o_frame_err);
      end else begin
        automatic bit e = exp_q.pop_front();
        if (o_frame_ok !== e || o_frame_err !== !e) begin
          n_bad++;
          $display("FAIL pulse_kind: ok=%0b err=%0b expected ok=%0b err=%0b",
                   o_frame_ok, o_frame_err, e, !e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; i_enable = 1'b1; i_clr = 1'b0;
    i_rkmsb = 1'b0; i_rklsb = 1'b0; i_rxd = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sync", o_sync, 0);
    chk("rst_pulses", {o_frame_ok, o_frame_err}, 0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    chk("rst_ferr_cnt", o_ferr_cnt, 0);
    chk("rst_werr_cnt", o_werr_cnt, 0);
    chk("rst_err_idx", o_err_idx, 0);
    chk("rst_err_word", o_err_word, 0);
    rst = 1'b0;

    // Four good frames reach lock
    for (int f = 0; f < 3; f++) send_frame(-1, 16'h0, 1'b0);
    chk("lock_not_yet", o_sync, 0);
    send_frame(-1, 16'h0, 1'b0);
    send(1'b0, 1'b0, 16'h0000);
    chk("lock_sync", o_sync, 1);
    chk("lock_frame_cnt", o_frame_cnt, 4);
    chk("lock_werr_cnt", o_werr_cnt, 0);

    // Bad payload word 7 while locked
    send_frame(7, 16'h0807, 1'b0);
    send(1'b0, 1'b0, 16'h0000);
    chk("bad_werr_cnt", o_werr_cnt, 1);
    chk("bad_ferr_cnt", o_ferr_cnt, 1);
    chk("bad_sync", o_sync, 0);
`ifdef TLK2711_RX_ERRCAP_EN
    chk("bad_err_idx", o_err_idx, 7);
    chk("bad_err_word", o_err_word, 16'h0807);
`else
    chk("bad_err_idx", o_err_idx, 0);
    chk("bad_err_word", o_err_word, 0);
`endif

    // Comma after payload index 10 truncates; next SOF frame checks normally
    comma(); comma(); sof();
    data_run(0, 10);
    exp_q.push_back(1'b0);
    comma();
    chk("trunc_ferr_cnt", o_ferr_cnt, 2);
    chk("trunc_werr_cnt", o_werr_cnt, 1);
    sof();
    data_run(0, 30);
    exp_q.push_back(1'b1);
    data_run(31, 31);
    chk("trunc_next_frame_cnt", o_frame_cnt, 5);

    // Clear on the edge that ends a good frame
    send_frame(-1, 16'h0, 1'b1);
    chk("clr_frame_cnt", o_frame_cnt, 0);
    chk("clr_ferr_cnt", o_ferr_cnt, 0);
    chk("clr_werr_cnt", o_werr_cnt, 0);

    // Continuous comma stream
    for (int c = 0; c < 1000; c++) comma();
    chk("comma_frame_cnt", o_frame_cnt, 0);
    chk("comma_ferr_cnt", o_ferr_cnt, 0);
    chk("comma_werr_cnt", o_werr_cnt, 0);

    // Disable mid-frame discards the frame silently
    send_frame(-1, 16'h0, 1'b0);
    comma(); comma(); sof();
    data_run(0, 5);
    i_enable = 1'b0;
    data_run(6, 6);
    chk("dis_sync", o_sync, 0);
    i_enable = 1'b1;
    data_run(7, 31);
    chk("dis_frame_cnt", o_frame_cnt, 1);
    chk("dis_ferr_cnt", o_ferr_cnt, 0);

    // Reset at payload index 15
    comma(); comma(); sof();
    data_run(0, 14);
    rst = 1'b1;
    data_run(15, 15);
    chk("midrst_frame_cnt", o_frame_cnt, 0);
    chk("midrst_pulses", {o_frame_ok, o_frame_err}, 0);
    chk("midrst_sync", o_sync, 0);
    rst = 1'b0;
    data_run(16, 31);
    sof();
    data_run(0, 31);
    chk("postrst_frame_cnt", o_frame_cnt, 0);
    chk("postrst_werr_cnt", o_werr_cnt, 0);
    chk("postrst_ferr_cnt", o_ferr_cnt, 0);
    send_frame(-1, 16'h0, 1'b0);
    send(1'b0, 1'b0, 16'h0000);
    chk("resume_frame_cnt", o_frame_cnt, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
